clk_div_multi: RTL

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_multi.sv | 115 +++++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider. Each channel runs a wrap
// counter against its active divisor and swaps in a newly loaded divisor only at a period boundary.
module clk_div_multi #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] div,
    input  logic [CHANNELS-1:0]       load,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       pending
);

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_D = (DEFAULT_DIV < 2) ? TWO : WIDTH'(DEFAULT_DIV);

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
        return (v < TWO) ? TWO : v;
    endfunction

    // ceil(d/2) without widening: d>>1 plus the dropped LSB
    function automatic logic [WIDTH-1:0] half_of(input logic [WIDTH-1:0] d);
        return (d >> 1) + WIDTH'(d[0]);
    endfunction

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [WIDTH-1:0] d_q,   d_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] p_q,   p_d;
        logic             pend_q, pend_d;
        logic             out_q,  out_d;
        logic             tick_q, tick_d;
        logic [WIDTH-1:0] req_div;
        logic             wrap;

        assign req_div = clamp_div(div[ch*WIDTH +: WIDTH]);
        assign wrap    = (cnt_q == d_q - ONE);

        always_comb begin
            d_d    = d_q;
            cnt_d  = cnt_q;
            p_d    = p_q;
            pend_d = pend_q;
            out_d  = 1'b0;
            tick_d = 1'b0;
            if (en[ch]) begin
                if (wrap) begin
                    // a load coinciding with the wrap bypasses the pending slot
                    cnt_d  = '0;
                    pend_d = 1'b0;
                    if (load[ch]) begin
                        d_d = req_div;
                        p_d = req_div;
                    end else if (pend_q) begin
                        d_d = p_q;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (load[ch]) begin
                        p_d    = req_div;
                        pend_d = 1'b1;
                    end
                end
                out_d  = (cnt_d < half_of(d_d));
                tick_d = (cnt_d == '0);
            end else begin
                // idle: apply any new divisor at once and park the counter at D-1
                pend_d = 1'b0;
                if (load[ch]) begin
                    d_d = req_div;
                    p_d = req_div;
                end else if (pend_q) begin
                    d_d = p_q;
                end
                cnt_d = d_d - ONE;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q    <= RST_D;
                cnt_q  <= RST_D - ONE;
                p_q    <= RST_D;
                pend_q <= 1'b0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                d_q    <= d_d;
                cnt_q  <= cnt_d;
                p_q    <= p_d;
                pend_q <= pend_d;
                out_q  <= out_d;
                tick_q <= tick_d;
            end
        end

        always_ff @(posedge clk) begin
            if (rst_n) begin
                assert (d_q >= TWO);
                assert (cnt_q < d_q);
                assert (!tick_q || out_q);
            end
        end

        assign out[ch]     = out_q;
        assign tick[ch]    = tick_q;
        assign pending[ch] = pend_q;
    end

endmodule
